// File: rtl/axis_cic_interpolator.sv
//-----------------------------------------------------------------------------
// Module  : axis_cic_interpolator
// Purpose : N-stage CIC interpolator (R = 2**LOG2_R) with AXI-Stream ports.
//           Optional macro AXIS_CIC_INTERP_ROUND_EN selects round-half-up output.
// Revision: 1.0
//-----------------------------------------------------------------------------
`default_nettype none

module axis_cic_interpolator #(
   parameter int WIDTH  = 16,
   parameter int N      = 3,
   parameter int LOG2_R = 4
) (
   input  logic             aclk,
   input  logic             arst_n,
   input  logic [WIDTH-1:0] s_axis_data_tdata,
   input  logic             s_axis_data_tvalid,
   output logic             s_axis_data_tready,
   output logic [WIDTH-1:0] m_axis_data_tdata,
   output logic             m_axis_data_tvalid,
   input  logic             m_axis_data_tready
);

   localparam int WI    = WIDTH + N*LOG2_R;
   localparam int SHIFT = (N-1)*LOG2_R;
   localparam logic [LOG2_R-1:0] PHASE_LAST = '1;
   localparam logic signed [WI-1:0] RND = WI'((2**SHIFT)/2);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   logic [0:0]              state_q, state_d;
   logic [LOG2_R-1:0]       phase_q, phase_d;
   logic                    step, accept, last;

   logic signed [WI-1:0]    comb_c     [N+1];
   logic signed [WI-1:0]    comb_dly_q [N];
   logic signed [WI-1:0]    comb_out_q;
   logic signed [WI-1:0]    integ_q    [N];
   logic signed [WI-1:0]    integ_d    [N];
   logic signed [WI-1:0]    stuffed, out_full;

   logic [WIDTH-1:0]        m_tdata_q, m_tdata_d;
   logic                    m_tvalid_q;

   assign last   = (phase_q == PHASE_LAST);
   assign accept = s_axis_data_tvalid && s_axis_data_tready;

   always_ff @(posedge aclk) begin
      if (!arst_n) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (accept)             state_d = S_RUN;
      else if (step && last)  state_d = S_IDLE;
   end

   always_comb begin
      step               = (state_q == S_RUN) && (!m_tvalid_q || m_axis_data_tready);
      s_axis_data_tready = arst_n && ((state_q == S_IDLE) || (step && last));
   end

   assign comb_c[0] = {{(WI-WIDTH){s_axis_data_tdata[WIDTH-1]}}, s_axis_data_tdata};

   for (genvar k = 0; k < N; k++) begin : g_comb
      assign comb_c[k+1] = comb_c[k] - comb_dly_q[k];
   end

   // Zero-stuffing: only phase 0 of each input period injects the comb output.
   assign stuffed    = (phase_q == '0) ? comb_out_q : '0;
   assign integ_d[0] = integ_q[0] + stuffed;

   for (genvar k = 1; k < N; k++) begin : g_integ
      assign integ_d[k] = integ_q[k] + integ_d[k-1];
   end

`ifdef AXIS_CIC_INTERP_ROUND_EN
   assign out_full = integ_d[N-1] + RND;
`else
   assign out_full = integ_d[N-1];
`endif
   assign m_tdata_d = WIDTH'(out_full >>> SHIFT);

   always_comb begin
      phase_d = phase_q;
      if (step)   phase_d = phase_q + 1'b1;
      if (accept) phase_d = '0;
   end

   always_ff @(posedge aclk) begin
      if (!arst_n) begin
         comb_out_q <= '0;
         phase_q    <= '0;
         m_tdata_q  <= '0;
         m_tvalid_q <= 1'b0;
         for (int k = 0; k < N; k++) begin
            comb_dly_q[k] <= '0;
            integ_q[k]    <= '0;
         end
      end else begin
         phase_q <= phase_d;
         if (accept) begin
            comb_out_q <= comb_c[N];
            for (int k = 0; k < N; k++) comb_dly_q[k] <= comb_c[k];
         end
         if (step) begin
            m_tdata_q  <= m_tdata_d;
            m_tvalid_q <= 1'b1;
            for (int k = 0; k < N; k++) integ_q[k] <= integ_d[k];
         end
      end
   end

   assign m_axis_data_tdata  = m_tdata_q;
   assign m_axis_data_tvalid = m_tvalid_q;

endmodule

`default_nettype wire

// File: tb/tb_axis_cic_interpolator.sv
//-----------------------------------------------------------------------------
// Module  : tb_axis_cic_interpolator
// Purpose : Scoreboard bench; reference is a direct convolution with the
//           cascaded-boxcar impulse response of the interpolator.
// Revision: 1.0
//-----------------------------------------------------------------------------
`default_nettype none

module tb_axis_cic_interpolator;

   localparam int WIDTH  = 16;
   localparam int N      = 3;
   localparam int LOG2_R = 4;
   localparam int R      = 2**LOG2_R;
   localparam int SHIFT  = (N-1)*LOG2_R;
   localparam int HLEN   = N*(R-1) + 1;
`ifdef AXIS_CIC_INTERP_ROUND_EN
   localparam longint RND = longint'((2**SHIFT)/2);
   localparam logic [15:0] EXP_ROUND_FIRST = 16'h0002;
`else
   localparam longint RND = 0;
   localparam logic [15:0] EXP_ROUND_FIRST = 16'h0001;
`endif

   logic             clk = 1'b0;
   logic             arst_n;
   logic [WIDTH-1:0] s_tdata, m_tdata, s1_tdata, m1_tdata;
   logic             s_tvalid, s_tready, m_tvalid, m_tready;
   logic             s1_tvalid, s1_tready, m1_tvalid, m1_tready;

   int checks = 0;
   int failures = 0;

   longint      h [HLEN];
   longint      hist [$];
   logic [15:0] src_q [$];
   logic [15:0] exp_q [$];
   logic [15:0] got [$];
   int          n_in, n_out;

   always #5 clk = ~clk;

   axis_cic_interpolator #(.WIDTH(WIDTH), .N(N), .LOG2_R(LOG2_R)) dut (
      .aclk(clk), .arst_n(arst_n),
      .s_axis_data_tdata(s_tdata), .s_axis_data_tvalid(s_tvalid), .s_axis_data_tready(s_tready),
      .m_axis_data_tdata(m_tdata), .m_axis_data_tvalid(m_tvalid), .m_axis_data_tready(m_tready));

   axis_cic_interpolator #(.WIDTH(WIDTH), .N(1), .LOG2_R(2)) dut1 (
      .aclk(clk), .arst_n(arst_n),
      .s_axis_data_tdata(s1_tdata), .s_axis_data_tvalid(s1_tvalid), .s_axis_data_tready(s1_tready),
      .m_axis_data_tdata(m1_tdata), .m_axis_data_tvalid(m1_tvalid), .m_axis_data_tready(m1_tready));

   // Impulse response = N-fold convolution of a length-R boxcar.
   task automatic build_h();
      longint t [HLEN];
      for (int i = 0; i < HLEN; i++) h[i] = (i == 0) ? 1 : 0;
      for (int s = 0; s < N; s++) begin
         for (int i = 0; i < HLEN; i++) begin
            t[i] = 0;
            for (int j = 0; j < R; j++) if (i - j >= 0) t[i] += h[i-j];
         end
         for (int i = 0; i < HLEN; i++) h[i] = t[i];
      end
   endtask

   function automatic logic [15:0] model_out(input int n);
      longint acc = 0;
      logic [63:0] res;
      for (int m = 0; m < hist.size(); m++) begin
         int k = n - m*R;
         if (k >= 0 && k < HLEN) acc += hist[m] * h[k];
      end
      res = 64'((acc + RND) >>> SHIFT);
      return res[15:0];
   endfunction

   task automatic do_reset();
      arst_n = 1'b0; s_tvalid = 1'b0; s1_tvalid = 1'b0; m_tready = 1'b1;
      repeat (2) @(posedge clk);
      #1 arst_n = 1'b1;
      hist.delete(); exp_q.delete(); n_in = 0; n_out = 0;
   endtask

   task automatic run_stream(input bit rnd_ready, input string name);
      int budget = 0;
      bit stalled = 0;
      logic [15:0] hold = '0;
      do_reset();
      got.delete();
      while ((src_q.size() > 0 || exp_q.size() > 0) && budget < 20000) begin
         m_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         s_tvalid = (src_q.size() > 0);
         s_tdata  = s_tvalid ? src_q[0] : '0;
         #1;
         if (stalled) begin
            checks++;
            if (m_tdata !== hold || m_tvalid !== 1'b1) begin
               failures++;
               $display("FAIL %s_stall: tdata=%h tvalid=%b, required tdata=%h tvalid=1", name, m_tdata, m_tvalid, hold);
            end
         end
         stalled = 0;
         if (m_tvalid && exp_q.size() > 0) begin
            if (m_tready) begin
               checks++;
               if (m_tdata !== exp_q[0]) begin
                  failures++;
                  $display("FAIL %s_beat%0d: got %h expected %h", name, n_out, m_tdata, exp_q[0]);
               end
               got.push_back(m_tdata);
               void'(exp_q.pop_front());
               n_out++;
            end else begin
               stalled = 1; hold = m_tdata;
            end
         end
         if (s_tvalid && s_tready) begin
            hist.push_back(longint'($signed(s_tdata)));
            for (int p = 0; p < R; p++) exp_q.push_back(model_out((hist.size()-1)*R + p));
            void'(src_q.pop_front());
            n_in++;
         end
         @(posedge clk); #1;
         budget++;
      end
      s_tvalid = 1'b0; m_tready = 1'b1;
      checks++;
      if (exp_q.size() != 0 || n_in*R != n_out) begin
         failures++;
         $display("FAIL %s_count: inputs=%0d outputs=%0d pending=%0d, required outputs=%0d", name, n_in, n_out, exp_q.size(), n_in*R);
      end
   endtask

   task automatic test_reset();
      arst_n = 1'b0; s_tvalid = 1'b0; s1_tvalid = 1'b0; m_tready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (s_tready !== 1'b0 || s1_tready !== 1'b0) begin
         failures++;
         $display("FAIL reset_tready_low: s_tready=%b s1_tready=%b required 0", s_tready, s1_tready);
      end
      @(posedge clk); #1;
      checks++;
      if (m_tvalid !== 1'b0 || m_tdata !== 16'h0000) begin
         failures++;
         $display("FAIL reset_outputs: tvalid=%b tdata=%h required 0/0000", m_tvalid, m_tdata);
      end
      arst_n = 1'b1; #1;
      checks++;
      if (s_tready !== 1'b1) begin
         failures++;
         $display("FAIL reset_idle_ready: s_tready=%b required 1", s_tready);
      end
   endtask

   task automatic test_n1();
      logic [15:0] outs [$];
      logic [15:0] expv [8] = '{16'd5, 16'd5, 16'd5, 16'd5, 16'hFFFD, 16'hFFFD, 16'hFFFD, 16'hFFFD};
      int k = 0;
      do_reset();
      m1_tready = 1'b1;
      for (int cyc = 0; cyc < 11; cyc++) begin
         s1_tvalid = (k < 2);
         s1_tdata  = (k == 0) ? 16'd5 : 16'hFFFD;
         #1;
         if (cyc <= 8) begin
            checks++;
            if (s1_tready !== (cyc % 4 == 0)) begin
               failures++;
               $display("FAIL n1_s_tready_cyc%0d: got %b required %b", cyc, s1_tready, (cyc % 4 == 0));
            end
         end
         if (m1_tvalid && outs.size() < 8) outs.push_back(m1_tdata);
         if (s1_tvalid && s1_tready) k++;
         @(posedge clk); #1;
      end
      s1_tvalid = 1'b0;
      checks++;
      if (outs.size() != 8) begin
         failures++;
         $display("FAIL n1_count: got %0d beats required 8", outs.size());
      end
      for (int i = 0; i < outs.size(); i++) begin
         checks++;
         if (outs[i] !== expv[i]) begin
            failures++;
            $display("FAIL n1_beat%0d: got %h required %h", i, outs[i], expv[i]);
         end
      end
   endtask

   task automatic test_const();
      repeat (64) src_q.push_back(16'h1000);
      run_stream(0, "const");
      checks++;
      if (got.size() < 64 || got[0] !== 16'h0010) begin
         failures++;
         $display("FAIL const_first: got %h (beats %0d) required 0010", (got.size() > 0) ? got[0] : 16'hxxxx, got.size());
      end
      for (int i = 1; i < got.size(); i++) begin
         checks++;
         if ($signed(got[i]) < $signed(got[i-1])) begin
            failures++;
            $display("FAIL const_monotonic%0d: got %h after %h", i, got[i], got[i-1]);
         end
         if (i >= 48) begin
            checks++;
            if (got[i] !== 16'h1000) begin
               failures++;
               $display("FAIL const_settled%0d: got %h required 1000", i, got[i]);
            end
         end
      end
   endtask

   task automatic test_extremes();
      repeat (8) src_q.push_back(16'h8000);
      repeat (8) src_q.push_back(16'h7FFF);
      run_stream(0, "extreme");
      checks++;
      if (got.size() != 256 || got[127] !== 16'h8000 || got[255] !== 16'h7FFF) begin
         failures++;
         $display("FAIL extreme_settle: beats=%0d got[127]=%h got[255]=%h required 8000/7fff",
                  got.size(), (got.size() > 127) ? got[127] : 16'hxxxx, (got.size() > 255) ? got[255] : 16'hxxxx);
      end
   endtask

   task automatic test_random_backpressure();
      logic [15:0] rs [40];
      logic [15:0] ref_got [$];
      for (int i = 0; i < 40; i++) rs[i] = 16'($urandom);
      for (int i = 0; i < 40; i++) src_q.push_back(rs[i]);
      run_stream(0, "rand_free");
      ref_got = got;
      for (int i = 0; i < 40; i++) src_q.push_back(rs[i]);
      run_stream(1, "rand_bp");
      checks++;
      if (got.size() != ref_got.size()) begin
         failures++;
         $display("FAIL rand_identical_len: got %0d beats required %0d", got.size(), ref_got.size());
      end else begin
         for (int i = 0; i < got.size(); i++) begin
            checks++;
            if (got[i] !== ref_got[i]) begin
               failures++;
               $display("FAIL rand_identical%0d: got %h required %h", i, got[i], ref_got[i]);
            end
         end
      end
   endtask

   task automatic test_reset_midrun();
      int w = 0;
      do_reset();
      s_tvalid = 1'b1; s_tdata = 16'h1000; m_tready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
      end
      arst_n = 1'b0;
      @(posedge clk); #1;
      arst_n = 1'b1; #1;
      checks++;
      if (m_tvalid !== 1'b0 || s_tready !== 1'b1) begin
         failures++;
         $display("FAIL midreset_state: tvalid=%b s_tready=%b required 0/1", m_tvalid, s_tready);
      end
      @(posedge clk); #1;
      s_tvalid = 1'b0;
      while (!m_tvalid && w < 10) begin
         @(posedge clk); #1;
         w++;
      end
      checks++;
      if (m_tvalid !== 1'b1 || m_tdata !== 16'h0010) begin
         failures++;
         $display("FAIL midreset_first: tvalid=%b tdata=%h required 1/0010", m_tvalid, m_tdata);
      end
   endtask

   task automatic test_round();
      src_q.push_back(16'h0180);
      repeat (3) src_q.push_back(16'h0000);
      run_stream(0, "round");
      checks++;
      if (got.size() == 0 || got[0] !== EXP_ROUND_FIRST) begin
         failures++;
         $display("FAIL round_first: got %h required %h", (got.size() > 0) ? got[0] : 16'hxxxx, EXP_ROUND_FIRST);
      end
   endtask

   initial begin
      arst_n = 1'b0; s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b1;
      s1_tvalid = 1'b0; s1_tdata = '0; m1_tready = 1'b1;
      build_h();
      #1;
      test_reset();
      test_n1();
      test_const();
      test_extremes();
      test_random_backpressure();
      test_reset_midrun();
      test_round();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
